// File: rtl/mem_arb_if.sv
// Requester and memory bus bundle for mem_arb.
// The master side drives requests and memory read data; the arbiter is the slave.
interface mem_arb_if;
    logic        REQ0;
    logic        RW0;
    logic [25:0] ADDR0;
    logic [31:0] WDATA0;
    logic        REQ1;
    logic        RW1;
    logic [25:0] ADDR1;
    logic [31:0] WDATA1;
    logic        GNT0;
    logic        GNT1;
    logic        ACK0;
    logic        ACK1;
    logic [31:0] RDATA;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [25:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [31:0] MEM_RDATA;

    modport master (
        output REQ0, RW0, ADDR0, WDATA0,
        output REQ1, RW1, ADDR1, WDATA1,
        output MEM_RDATA,
        input  GNT0, GNT1, ACK0, ACK1, RDATA,
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );

    modport slave (
        input  REQ0, RW0, ADDR0, WDATA0,
        input  REQ1, RW1, ADDR1, WDATA1,
        input  MEM_RDATA,
        output GNT0, GNT1, ACK0, ACK1, RDATA,
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester round-robin memory arbiter: IDLE -> ACCESS -> DONE,
// strobes held for WAIT_CYCLES cycles, one-cycle ACK, registered outputs.
module mem_arb #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ0,
    input  logic        RW0,
    input  logic [25:0] ADDR0,
    input  logic [31:0] WDATA0,
    input  logic        REQ1,
    input  logic        RW1,
    input  logic [25:0] ADDR1,
    input  logic [31:0] WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        ACK0,
    output logic        ACK1,
    output logic [31:0] RDATA,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [25:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int         WE   = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam logic [3:0] LOAD = 4'(WE - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        owner_q, owner_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [25:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        r0, r1;

    // X/Z on a request line falls to the else branch and counts as idle
    always_comb begin
        r0 = 1'b0;
        r1 = 1'b0;
        if (REQ0) r0 = 1'b1;
        if (REQ1) r1 = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (r0 && (!r1 || !prio_q)) begin
                    state_d = S_ACCESS;
                    cnt_d   = LOAD;
                    owner_d = 1'b0;
                    gnt0_d  = 1'b1;
                    rd_d    = !RW0;
                    wr_d    = RW0;
                    addr_d  = ADDR0;
                    wdata_d = WDATA0;
                end else if (r1) begin
                    state_d = S_ACCESS;
                    cnt_d   = LOAD;
                    owner_d = 1'b1;
                    gnt1_d  = 1'b1;
                    rd_d    = !RW1;
                    wr_d    = RW1;
                    addr_d  = ADDR1;
                    wdata_d = WDATA1;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = !owner_q;
                    ack1_d  = owner_q;
                    // priority passes to whoever was not just served
                    prio_d  = !owner_q;
                    if (rd_q) rdata_d = MEM_RDATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 26'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign RDATA     = rdata_q;
    assign MEM_READ  = rd_q;
    assign MEM_WRITE = wr_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: per-cycle vector table plus reset,
// strobe-width and exclusivity sequences.
module tb_mem_arb;
    logic CLK = 1'b0;
    logic RST;
    mem_arb_if bus ();

    always #5 CLK = ~CLK;

    mem_arb #(.WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(bus.REQ0), .RW0(bus.RW0), .ADDR0(bus.ADDR0), .WDATA0(bus.WDATA0),
        .REQ1(bus.REQ1), .RW1(bus.RW1), .ADDR1(bus.ADDR1), .WDATA1(bus.WDATA1),
        .GNT0(bus.GNT0), .GNT1(bus.GNT1), .ACK0(bus.ACK0), .ACK1(bus.ACK1),
        .RDATA(bus.RDATA), .MEM_READ(bus.MEM_READ), .MEM_WRITE(bus.MEM_WRITE),
        .MEM_ADDR(bus.MEM_ADDR), .MEM_WDATA(bus.MEM_WDATA),
        .MEM_RDATA(bus.MEM_RDATA)
    );

    logic        z_g0, z_g1, z_a0, z_a1, z_rd, z_wr;
    logic [31:0] z_rdata, z_wdata;
    logic [25:0] z_addr;
    mem_arb #(.WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST(RST),
        .REQ0(bus.REQ0), .RW0(bus.RW0), .ADDR0(bus.ADDR0), .WDATA0(bus.WDATA0),
        .REQ1(bus.REQ1), .RW1(bus.RW1), .ADDR1(bus.ADDR1), .WDATA1(bus.WDATA1),
        .GNT0(z_g0), .GNT1(z_g1), .ACK0(z_a0), .ACK1(z_a1),
        .RDATA(z_rdata), .MEM_READ(z_rd), .MEM_WRITE(z_wr),
        .MEM_ADDR(z_addr), .MEM_WDATA(z_wdata), .MEM_RDATA(bus.MEM_RDATA)
    );

    logic        f_g0, f_g1, f_a0, f_a1, f_rd, f_wr;
    logic [31:0] f_rdata, f_wdata;
    logic [25:0] f_addr;
    mem_arb #(.WAIT_CYCLES(15)) dut15 (
        .CLK(CLK), .RST(RST),
        .REQ0(bus.REQ0), .RW0(bus.RW0), .ADDR0(bus.ADDR0), .WDATA0(bus.WDATA0),
        .REQ1(bus.REQ1), .RW1(bus.RW1), .ADDR1(bus.ADDR1), .WDATA1(bus.WDATA1),
        .GNT0(f_g0), .GNT1(f_g1), .ACK0(f_a0), .ACK1(f_a1),
        .RDATA(f_rdata), .MEM_READ(f_rd), .MEM_WRITE(f_wr),
        .MEM_ADDR(f_addr), .MEM_WDATA(f_wdata), .MEM_RDATA(bus.MEM_RDATA)
    );

    typedef struct {
        logic        r0, w0;
        logic [25:0] a0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [25:0] a1;
        logic [31:0] d1;
        logic [31:0] mrd;
        logic [5:0]  fl;
        logic [25:0] ma;
        logic [31:0] md;
        logic [31:0] rdat;
    } vec_t;

    // flags are {GNT0, GNT1, ACK0, ACK1, MEM_READ, MEM_WRITE}
    localparam logic [5:0] IDL  = 6'b000000;
    localparam logic [5:0] G0RD = 6'b100010;
    localparam logic [5:0] G0WR = 6'b100001;
    localparam logic [5:0] G0AK = 6'b101000;
    localparam logic [5:0] G1RD = 6'b010010;
    localparam logic [5:0] G1WR = 6'b010001;
    localparam logic [5:0] G1AK = 6'b010100;

    int errors = 0;
    int checks = 0;
    int viol   = 0;
    vec_t vt[$];

    function automatic vec_t mk(
        logic r0, logic w0, logic [25:0] a0, logic [31:0] d0,
        logic r1, logic w1, logic [25:0] a1, logic [31:0] d1,
        logic [31:0] mrd, logic [5:0] fl, logic [25:0] ma,
        logic [31:0] md, logic [31:0] rdat);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.mrd = mrd; v.fl = fl; v.ma = ma; v.md = md; v.rdat = rdat;
        return v;
    endfunction

    task automatic check(string name, logic [95:0] got, logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    function automatic logic [95:0] snap();
        return {bus.GNT0, bus.GNT1, bus.ACK0, bus.ACK1,
                bus.MEM_READ, bus.MEM_WRITE,
                bus.MEM_ADDR, bus.MEM_WDATA, bus.RDATA};
    endfunction

    always @(negedge CLK) begin
        if ((bus.GNT0 && bus.GNT1) || (bus.ACK0 && bus.ACK1) ||
            (bus.MEM_READ && bus.MEM_WRITE)) viol++;
        if ((z_g0 && z_g1) || (z_a0 && z_a1) || (z_rd && z_wr)) viol++;
        if ((f_g0 && f_g1) || (f_a0 && f_a1) || (f_rd && f_wr)) viol++;
    end

    task automatic drive(vec_t v);
        bus.REQ0 = v.r0; bus.RW0 = v.w0; bus.ADDR0 = v.a0; bus.WDATA0 = v.d0;
        bus.REQ1 = v.r1; bus.RW1 = v.w1; bus.ADDR1 = v.a1; bus.WDATA1 = v.d1;
        bus.MEM_RDATA = v.mrd;
    endtask

    initial begin
        int ackseen, w0c, w2c, w15c, a0c, a2c, a15c;
        bit found;

        // single read, then single write
        vt.push_back(mk(1,0,'h10,'hAAAA5555, 0,0,0,0, 0,           G0RD,'h10,'hAAAA5555,0));
        vt.push_back(mk(0,0,'h10,'hAAAA5555, 0,0,0,0, 'hDEADBEEF,  G0RD,'h10,'hAAAA5555,0));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'hDEADBEEF, G0AK,'h10,'hAAAA5555,'hDEADBEEF));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,          IDL, 'h10,'hAAAA5555,'hDEADBEEF));
        vt.push_back(mk(0,0,0,0, 1,1,'h3FFFFFF,'h12345678, 0, G1WR,'h3FFFFFF,'h12345678,'hDEADBEEF));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h0BADF00D, G1WR,'h3FFFFFF,'h12345678,'hDEADBEEF));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h0BADF00D, G1AK,'h3FFFFFF,'h12345678,'hDEADBEEF));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,          IDL, 'h3FFFFFF,'h12345678,'hDEADBEEF));
        // contention: both held, grants alternate 0,1,0
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h11111111, G0RD,'h100,0,'hDEADBEEF));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h11111111, G0RD,'h100,0,'hDEADBEEF));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h11111111, G0AK,'h100,0,'h11111111));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h22222222, IDL, 'h100,0,'h11111111));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h22222222, G1RD,'h200,0,'h11111111));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h22222222, G1RD,'h200,0,'h11111111));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h22222222, G1AK,'h200,0,'h22222222));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h33333333, IDL, 'h200,0,'h22222222));
        vt.push_back(mk(1,0,'h100,0, 1,0,'h200,0, 'h33333333, G0RD,'h100,0,'h22222222));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h33333333, G0RD,'h100,0,'h22222222));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h33333333, G0AK,'h100,0,'h33333333));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,          IDL, 'h100,0,'h33333333));
        // lone REQ0 wins against pointer; early drop; REQ1 arrives mid-access
        vt.push_back(mk(1,1,'h5,'hCAFEF00D, 0,0,0,0, 0, G0WR,'h5,'hCAFEF00D,'h33333333));
        vt.push_back(mk(0,0,0,0, 1,0,'h77,0, 0, G0WR,'h5,'hCAFEF00D,'h33333333));
        vt.push_back(mk(0,0,0,0, 1,0,'h77,0, 0, G0AK,'h5,'hCAFEF00D,'h33333333));
        vt.push_back(mk(0,0,0,0, 1,0,'h77,0, 0, IDL, 'h5,'hCAFEF00D,'h33333333));
        vt.push_back(mk(0,0,0,0, 1,0,'h77,0, 0, G1RD,'h77,0,'h33333333));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h44444444, G1RD,'h77,0,'h33333333));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 'h44444444, G1AK,'h77,0,'h44444444));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,          IDL, 'h77,0,'h44444444));
        // X on request lines is no request
        vt.push_back(mk(1'bx,0,0,0, 0,0,0,0, 0,    IDL, 'h77,0,'h44444444));
        vt.push_back(mk(1'bx,0,0,0, 1'bx,0,0,0, 0, IDL, 'h77,0,'h44444444));
        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,       IDL, 'h77,0,'h44444444));

        RST = 1'b0;
        drive(mk(0,0,0,0, 0,0,0,0, 0, IDL,0,0,0));
        #12;
        check("reset_state", snap(), 96'd0);
        check("reset_w15", {f_g0, f_rd, f_addr, f_rdata}, 60'd0);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge CLK);
            drive(vt[i]);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d", i), snap(),
                  {vt[i].fl, vt[i].ma, vt[i].md, vt[i].rdat});
        end

        // reset in the second MEM_READ cycle
        @(negedge CLK);
        drive(mk(1,0,'h123,0, 0,0,0,0, 'h66666666, IDL,0,0,0));
        @(posedge CLK);
        @(negedge CLK);
        bus.REQ0 = 1'b0;
        @(posedge CLK);
        #1;
        check("mid_rd", {31'd0, bus.MEM_READ}, 32'd1);
        #3;
        RST = 1'b0;
        #1;
        check("async_rst", snap(), 96'd0);
        ackseen = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            if (i == 3) RST = 1'b1;
            if (bus.ACK0 || bus.ACK1) ackseen++;
        end
        check("no_ack", 96'(ackseen), 96'd0);

        // first arbitration after reset favours requester 0
        @(negedge CLK);
        drive(mk(1,0,'h124,0, 1,1,'h9,'h1, 'h55555555, IDL,0,0,0));
        @(posedge CLK);
        #1;
        check("post_rst_arb", {70'd0, bus.GNT0, bus.GNT1, bus.MEM_ADDR},
              {70'd0, 2'b10, 26'h124});
        @(negedge CLK);
        bus.REQ0 = 1'b0;
        bus.REQ1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (bus.ACK0) found = 1'b1;
        end
        check("post_rst_ack", {63'd0, found, bus.RDATA}, {63'd0, 1'b1, 32'h55555555});

        // strobe widths for WAIT_CYCLES 0, 2, 15
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        drive(mk(1,0,'h40,0, 0,0,0,0, 'h77777777, IDL,0,0,0));
        w0c = 0; w2c = 0; w15c = 0; a0c = 0; a2c = 0; a15c = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge CLK);
            w0c  += int'(z_rd);
            w2c  += int'(bus.MEM_READ);
            w15c += int'(f_rd);
            a0c  += int'(z_a0);
            a2c  += int'(bus.ACK0);
            a15c += int'(f_a0);
            bus.REQ0 = 1'b0;
        end
        check("width_w0",  96'(w0c),  96'd1);
        check("width_w2",  96'(w2c),  96'd2);
        check("width_w15", 96'(w15c), 96'd15);
        check("acks_once", {32'(a0c), 32'(a2c), 32'(a15c)}, {32'd1, 32'd1, 32'd1});
        check("rdata_w15", {64'd0, f_rdata}, {64'd0, 32'h77777777});
        check("exclusive", 96'(viol), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
